snn_layer_sequencer: RTL and testbench
======================================

Name: snn_layer_sequencer

Overview:
Controller for the 3-neuron spiking layer.
- Loads the layer's 72-bit weight vector and 32-bit parameter word byte-serially through a narrow 8-bit configuration port.
- Commits both atomically.
- Sequences timesteps: presents sampled input spikes, pulses the layer enable once per step, captures the layer's output spikes and accumulates per-neuron spike counts.
- Sits between the tile's 8-bit I/O and the layer instance.

Parameters:
CNT_W, 8, width of each per-neuron saturating spike counter.
STEP_W, 16, width of the wrapping timestep counter.

Ports:
clk  in  1  clock.
rst_n  in  1  reset, synchronous, active-low.
cfg_start  in  1  pulse: begin (or restart) a configuration load.
cfg_valid  in  1  cfg_byte valid this cycle.
cfg_byte  in  8  configuration byte.
run  in  1  level: run timesteps while high.
step_period  in  8  idle cycles between steps.
clr_counts  in  1  pulse: clear spike and step counters.
in_spikes  in  3  external spike inputs; sampled once per step.
layer_spike_out  in  3  spike outputs from the layer.
layer_input_spikes  out  3  spikes driven to the layer.
layer_weights  out  72  committed weights to the layer.
layer_params  out  32  committed {threshold, decay, refractory_period, feedback_scale}.
layer_enable  out  1  one-cycle layer update strobe.
cfg_loaded  out  1  a complete configuration has been committed.
busy  out  1  state is not IDLE.
spike_counts  out  3*CNT_W  neuron i count at [i*CNT_W +: CNT_W].
step_count  out  STEP_W  completed timesteps.

Behaviour:
- Reset (rst_n low at a clk edge):
  - All outputs and the shadow registers go to 0; state goes to IDLE; byte index goes to 0.
  - Reset during LOAD discards the partial load.
  - Reset during a run stops the run immediately.
- States: IDLE, LOAD, COMMIT, RUN_WAIT, STEP, CAPTURE.
- IDLE:
  - cfg_start -> LOAD with idx=0. cfg_start has priority over run.
  - Otherwise, run=1 and cfg_loaded=1 -> RUN_WAIT with wait_cnt=step_period.
  - run while cfg_loaded=0 is ignored.
- LOAD:
  - Each cycle with cfg_valid=1 writes cfg_byte to shadow byte idx, then idx++.
  - Byte order is MSB-first:
    - idx 0..8 map to weights [71:64] down to [7:0].
    - idx 9..12 map to params [31:24] down to [7:0].
  - The cycle accepting idx=12 -> COMMIT.
  - cfg_start in LOAD resets idx to 0 and ignores that cycle's byte.
  - cfg_valid gaps are allowed; there is no timeout.
  - run is ignored in LOAD.
- COMMIT (exactly 1 cycle):
  - layer_weights/layer_params <= shadow; cfg_loaded <= 1.
  - Spike counters and step_count clear.
  - -> IDLE.
  - Layer outputs never show a partially loaded configuration.
- RUN_WAIT:
  - If run=0 -> IDLE.
  - Else if wait_cnt==0 -> STEP, with layer_input_spikes <= in_spikes registered on this transition.
  - Else wait_cnt--.
  - RUN_WAIT lasts step_period+1 cycles. step_period=0 is legal.
- STEP (1 cycle): layer_enable=1 (registered, high only in this state); layer_input_spikes held. -> CAPTURE.
- CAPTURE (1 cycle):
  - Sample layer_spike_out, which reflects the neuron update made at the enable edge.
  - For each bit set, increment that counter, saturating at 2^CNT_W-1.
  - step_count++, wrapping.
  - layer_input_spikes <= 0; wait_cnt <= step_period; -> RUN_WAIT.
- Step timing:
  - Step period = step_period+3 cycles.
  - run deasserted in STEP or CAPTURE completes the current step, then exits from RUN_WAIT.
  - cfg_start during RUN_WAIT/STEP/CAPTURE is ignored; stop first, then reload.
- clr_counts is honoured in any state. It clears spike_counts and step_count on the next edge, and wins over a same-cycle CAPTURE increment.
- A reload while cfg_loaded=1 keeps the old layer_weights/layer_params until COMMIT.
- busy = (state != IDLE), registered with the state.

Test Plan:
- Reset: rst_n=0 for 2 cycles -> all outputs 0, busy=0. run=1 with no load -> stays IDLE, layer_enable never asserts.
- Load: cfg_start, then 13 bytes 0x01..0x0D with gaps -> one cycle after the last byte, layer_weights=0x010203040506070809, layer_params=0x0A0B0C0D, cfg_loaded=1, busy=0.
- Restart mid-load: 5 bytes, then cfg_start, then 13 bytes 0xF0..0xFC -> weights=0xF0F1F2F3F4F5F6F7F8, params=0xF9FAFBFC. Outputs unchanged before COMMIT.
- Timing: step_period=2, in_spikes=3'b101, run=1 for 3 steps -> layer_enable pulses exactly 5 cycles apart. layer_input_spikes=101 only in the cycles entering STEP through CAPTURE. step_count=3.
- Counting: model layer_spike_out=3'b011 in every CAPTURE, CNT_W=8, 300 steps -> counts {n2,n1,n0} = {0,255,255} (saturated); step_count=300.
- Clear/collision: clr_counts asserted in a CAPTURE cycle -> counts and step_count read 0 next cycle. run dropped during STEP -> one CAPTURE occurs, then IDLE.

Source files
------------

// File: rtl/snn_layer_sequencer_if.sv
// Configuration port plus the sequencer <-> layer connection.
// master: the tile/layer side (drives config bytes and the layer's spike outputs).
// slave : the sequencer.
interface snn_layer_sequencer_if;
  logic        cfg_start;
  logic        cfg_valid;
  logic [7:0]  cfg_byte;
  logic [2:0]  layer_spike_out;
  logic [2:0]  layer_input_spikes;
  logic [71:0] layer_weights;
  logic [31:0] layer_params;
  logic        layer_enable;

  modport master (
    output cfg_start, cfg_valid, cfg_byte, layer_spike_out,
    input  layer_input_spikes, layer_weights, layer_params, layer_enable
  );

  modport slave (
    input  cfg_start, cfg_valid, cfg_byte, layer_spike_out,
    output layer_input_spikes, layer_weights, layer_params, layer_enable
  );
endinterface

// File: rtl/snn_layer_sequencer.sv
// Layer sequencer: byte-serial config load with atomic commit, then
// timestep sequencing (wait, enable strobe, capture) with per-neuron
// saturating spike counters and a wrapping step counter.

// One per-neuron saturating spike counter.
module snn_spike_ctr #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);
  // clear beats increment; increment sticks at all-ones
  always_ff @(posedge clk) begin
    if (!rst_n)                  count <= '0;
    else if (clr)                count <= '0;
    else if (inc && count != '1) count <= count + CNT_W'(1);
  end
endmodule

module snn_layer_sequencer #(
  parameter int CNT_W  = 8,
  parameter int STEP_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  snn_layer_sequencer_if.slave   bus,
  input  logic                   run,
  input  logic [7:0]             step_period,
  input  logic                   clr_counts,
  input  logic [2:0]             in_spikes,
  output logic                   cfg_loaded,
  output logic                   busy,
  output logic [3*CNT_W-1:0]     spike_counts,
  output logic [STEP_W-1:0]      step_count
);
  localparam int NUM_N = 3;
  localparam logic [3:0] IDX_LAST = 4'd12;

  typedef enum logic [2:0] {
    IDLE, LOAD, COMMIT, RUN_WAIT, STEP, CAPTURE
  } state_t;

  state_t       state, state_nxt;
  logic [3:0]   idx;
  logic [103:0] shadow;      // {weights, params}, filled MSB-first by shifting
  logic [7:0]   wait_cnt;
  logic [71:0]  weights_q;
  logic [31:0]  params_q;
  logic [2:0]   in_q;
  logic         enable_q;
  logic         byte_take;
  logic         cnt_clr;

  assign bus.layer_weights      = weights_q;
  assign bus.layer_params       = params_q;
  assign bus.layer_input_spikes = in_q;
  assign bus.layer_enable       = enable_q;

  // a byte is taken in LOAD only when no restart is requested that cycle
  assign byte_take = (state == LOAD) && bus.cfg_valid && !bus.cfg_start;
  assign cnt_clr   = clr_counts || (state == COMMIT);

  // next-state selection
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.cfg_start)          state_nxt = LOAD;
        else if (run && cfg_loaded) state_nxt = RUN_WAIT;
      end
      LOAD:     if (byte_take && idx == IDX_LAST) state_nxt = COMMIT;
      COMMIT:   state_nxt = IDLE;
      RUN_WAIT: begin
        if (!run)                state_nxt = IDLE;
        else if (wait_cnt == '0) state_nxt = STEP;
      end
      STEP:     state_nxt = CAPTURE;
      CAPTURE:  state_nxt = RUN_WAIT;
      default:  state_nxt = IDLE;
    endcase
  end

  // state register, registered status strobes, load and step datapath
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      enable_q   <= 1'b0;
      idx        <= '0;
      shadow     <= '0;
      wait_cnt   <= '0;
      weights_q  <= '0;
      params_q   <= '0;
      in_q       <= '0;
      cfg_loaded <= 1'b0;
    end else begin
      state    <= state_nxt;
      busy     <= (state_nxt != IDLE);
      enable_q <= (state_nxt == STEP);
      case (state)
        IDLE: begin
          if (bus.cfg_start)          idx      <= '0;
          else if (run && cfg_loaded) wait_cnt <= step_period;
        end
        LOAD: begin
          if (bus.cfg_start) idx <= '0;
          else if (byte_take) begin
            shadow <= {shadow[95:0], bus.cfg_byte};
            idx    <= idx + 4'd1;
          end
        end
        COMMIT: begin
          weights_q  <= shadow[103:32];
          params_q   <= shadow[31:0];
          cfg_loaded <= 1'b1;
        end
        RUN_WAIT: begin
          if (run) begin
            if (wait_cnt == '0) in_q     <= in_spikes;
            else                wait_cnt <= wait_cnt - 8'd1;
          end
        end
        CAPTURE: begin
          in_q     <= '0;
          wait_cnt <= step_period;
        end
        default: ;
      endcase
    end
  end

  // completed-step counter, cleared by clr_counts or a new commit
  always_ff @(posedge clk) begin
    if (!rst_n)                step_count <= '0;
    else if (cnt_clr)          step_count <= '0;
    else if (state == CAPTURE) step_count <= step_count + STEP_W'(1);
  end

  for (genvar i = 0; i < NUM_N; i++) begin : g_ctr
    snn_spike_ctr #(.CNT_W(CNT_W)) u_ctr (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (cnt_clr),
      .inc   ((state == CAPTURE) && bus.layer_spike_out[i]),
      .count (spike_counts[i*CNT_W +: CNT_W])
    );
  end
endmodule

// File: tb/tb_snn_layer_sequencer.sv
// Bench for snn_layer_sequencer: scenario tasks with randomized config
// bytes, gaps, step periods and spike patterns against a plain model.
module tb_snn_layer_sequencer;
  localparam int CNT_W  = 8;
  localparam int STEP_W = 16;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 run = 1'b0;
  logic                 clr_counts = 1'b0;
  logic [7:0]           step_period = '0;
  logic [2:0]           in_spikes = '0;
  logic                 cfg_loaded, busy;
  logic [3*CNT_W-1:0]   spike_counts;
  logic [STEP_W-1:0]    step_count;

  snn_layer_sequencer_if bus();

  snn_layer_sequencer #(.CNT_W(CNT_W), .STEP_W(STEP_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .run          (run),
    .step_period  (step_period),
    .clr_counts   (clr_counts),
    .in_spikes    (in_spikes),
    .cfg_loaded   (cfg_loaded),
    .busy         (busy),
    .spike_counts (spike_counts),
    .step_count   (step_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // reference model
  logic [71:0] exp_w;
  logic [31:0] exp_p;
  logic        exp_loaded;
  int          exp_cnt [3];
  int          exp_steps;

  function automatic logic [3*CNT_W-1:0] cnt_vec();
    logic [3*CNT_W-1:0] v;
    for (int i = 0; i < 3; i++) v[i*CNT_W +: CNT_W] = CNT_W'(exp_cnt[i]);
    return v;
  endfunction

  task automatic model_reset();
    exp_w = '0; exp_p = '0; exp_loaded = 1'b0; exp_steps = 0;
    for (int i = 0; i < 3; i++) exp_cnt[i] = 0;
  endtask

  task automatic test_reset();
    int en_seen = 0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    n_chk++;
    if ({bus.layer_weights, bus.layer_params, bus.layer_enable, bus.layer_input_spikes,
         cfg_loaded, busy, spike_counts, step_count} !== '0)
      $display("FAIL reset_outputs: got w=%h p=%h en=%b ins=%b ld=%b busy=%b cnt=%h st=%h want all 0",
               bus.layer_weights, bus.layer_params, bus.layer_enable, bus.layer_input_spikes,
               cfg_loaded, busy, spike_counts, step_count);
    else n_pass++;
    rst_n = 1'b1;
    run = 1'b1;
    step_period = 8'd1;
    repeat (20) begin
      @(negedge clk);
      if (bus.layer_enable) en_seen++;
    end
    n_chk++;
    if (en_seen !== 0) $display("FAIL run_unloaded_enable: got %0d pulses want 0", en_seen);
    else n_pass++;
    n_chk++;
    if (busy !== 1'b0) $display("FAIL run_unloaded_busy: got %b want 0", busy);
    else n_pass++;
    run = 1'b0;
  endtask

  task automatic test_reset_mid_load();
    @(negedge clk); bus.cfg_start = 1'b1;
    @(negedge clk); bus.cfg_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.cfg_valid = 1'b1; bus.cfg_byte = 8'($urandom);
      @(negedge clk);
    end
    bus.cfg_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_chk++;
    if ({cfg_loaded, busy, bus.layer_weights, bus.layer_params} !== '0)
      $display("FAIL reset_mid_load: got ld=%b busy=%b w=%h p=%h want all 0",
               cfg_loaded, busy, bus.layer_weights, bus.layer_params);
    else n_pass++;
  endtask

  // prefix>0: send that many junk bytes, then a restart (with a junk byte
  // on the same cycle) before the 13 real bytes
  task automatic load_cfg(input logic [7:0] b [13], input int prefix);
    logic [7:0]  seq [$];
    bit          st  [$];
    logic [71:0] ow = exp_w;
    logic [31:0] op = exp_p;
    logic        ol = exp_loaded;
    for (int i = 0; i < prefix; i++) begin seq.push_back(8'($urandom)); st.push_back(1'b0); end
    if (prefix > 0) begin seq.push_back(8'hEE); st.push_back(1'b1); end
    for (int i = 0; i < 13; i++) begin seq.push_back(b[i]); st.push_back(1'b0); end
    @(negedge clk); bus.cfg_start = 1'b1;
    @(negedge clk); bus.cfg_start = 1'b0;
    for (int i = 0; i < seq.size(); i++) begin
      repeat ($urandom_range(0, 2)) begin
        bus.cfg_valid = 1'b0;
        @(negedge clk);
      end
      bus.cfg_start = st[i]; bus.cfg_valid = 1'b1; bus.cfg_byte = seq[i];
      @(negedge clk);
      bus.cfg_start = 1'b0; bus.cfg_valid = 1'b0;
      n_chk++;
      if ({bus.layer_weights, bus.layer_params, cfg_loaded} !== {ow, op, ol})
        $display("FAIL load_hold[%0d]: got w=%h p=%h ld=%b want w=%h p=%h ld=%b",
                 i, bus.layer_weights, bus.layer_params, cfg_loaded, ow, op, ol);
      else n_pass++;
    end
    n_chk++;
    if (busy !== 1'b1) $display("FAIL commit_busy: got %b want 1", busy);
    else n_pass++;
    @(negedge clk);
    exp_w = {b[0], b[1], b[2], b[3], b[4], b[5], b[6], b[7], b[8]};
    exp_p = {b[9], b[10], b[11], b[12]};
    exp_loaded = 1'b1;
    exp_steps = 0;
    for (int i = 0; i < 3; i++) exp_cnt[i] = 0;
    n_chk++;
    if (bus.layer_weights !== exp_w) $display("FAIL load_weights: got %h want %h", bus.layer_weights, exp_w);
    else n_pass++;
    n_chk++;
    if (bus.layer_params !== exp_p) $display("FAIL load_params: got %h want %h", bus.layer_params, exp_p);
    else n_pass++;
    n_chk++;
    if ({cfg_loaded, busy} !== 2'b10) $display("FAIL load_status: got ld=%b busy=%b want ld=1 busy=0", cfg_loaded, busy);
    else n_pass++;
    n_chk++;
    if ({spike_counts, step_count} !== '0)
      $display("FAIL commit_clear: got cnt=%h st=%h want 0", spike_counts, step_count);
    else n_pass++;
  endtask

  task automatic test_load();
    logic [7:0] b [13];
    for (int i = 0; i < 13; i++) b[i] = 8'(i + 1);
    load_cfg(b, 0);
  endtask

  task automatic test_restart();
    logic [7:0] b [13];
    for (int i = 0; i < 13; i++) b[i] = 8'(8'hF0 + i);
    load_cfg(b, 5);
  endtask

  task automatic test_reload_keeps();
    logic [7:0] b [13];
    for (int i = 0; i < 13; i++) b[i] = 8'($urandom);
    load_cfg(b, 3);
  endtask

  // run exactly n steps (run dropped while the n-th enable is high)
  task automatic run_steps(input int n, input logic [7:0] sp, input logic [2:0] spk, input int in_fix);
    int cyc = 0, steps = 0, last_en = 0, extra = 0;
    int per = int'(sp) + 3;
    logic [2:0] drv, held = '0;
    step_period = sp;
    bus.layer_spike_out = spk;
    drv = (in_fix < 0) ? 3'($urandom) : 3'(in_fix);
    @(negedge clk);
    run = 1'b1; in_spikes = drv;
    while (steps < n && cyc < n * per + 8) begin
      @(negedge clk); cyc++;
      if (bus.layer_enable) begin
        n_chk++;
        if (cyc - last_en !== ((steps == 0) ? per - 1 : per))
          $display("FAIL step_spacing[%0d]: got %0d want %0d", steps, cyc - last_en, (steps == 0) ? per - 1 : per);
        else n_pass++;
        n_chk++;
        if (bus.layer_input_spikes !== drv)
          $display("FAIL step_inputs[%0d]: got %b want %b", steps, bus.layer_input_spikes, drv);
        else n_pass++;
        held = drv; steps++; last_en = cyc;
        if (steps == n) run = 1'b0;
      end else if (steps > 0 && cyc == last_en + 1) begin
        n_chk++;
        if (bus.layer_input_spikes !== held)
          $display("FAIL capture_inputs[%0d]: got %b want %b", steps, bus.layer_input_spikes, held);
        else n_pass++;
      end else begin
        n_chk++;
        if (bus.layer_input_spikes !== 3'b000)
          $display("FAIL wait_inputs: got %b want 000", bus.layer_input_spikes);
        else n_pass++;
      end
      drv = (in_fix < 0) ? 3'($urandom) : 3'(in_fix);
      in_spikes = drv;
    end
    if (steps < n) begin
      n_chk++;
      $display("FAIL step_timeout: got %0d steps want %0d", steps, n);
      run = 1'b0;
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (bus.layer_enable) extra++;
      if (k == 1) begin
        n_chk++;
        if (busy !== 1'b1) $display("FAIL stop_wait_busy: got %b want 1", busy);
        else n_pass++;
      end
      if (k == 2) begin
        n_chk++;
        if (busy !== 1'b0) $display("FAIL stop_idle_busy: got %b want 0", busy);
        else n_pass++;
      end
    end
    repeat (per) begin
      @(negedge clk);
      if (bus.layer_enable) extra++;
    end
    n_chk++;
    if (extra !== 0) $display("FAIL stop_extra_enable: got %0d want 0", extra);
    else n_pass++;
    exp_steps += n;
    for (int i = 0; i < 3; i++)
      if (spk[i]) exp_cnt[i] = (exp_cnt[i] + n > CMAX) ? CMAX : exp_cnt[i] + n;
    n_chk++;
    if (spike_counts !== cnt_vec()) $display("FAIL spike_counts: got %h want %h", spike_counts, cnt_vec());
    else n_pass++;
    n_chk++;
    if (step_count !== STEP_W'(exp_steps)) $display("FAIL step_count: got %0d want %0d", step_count, exp_steps);
    else n_pass++;
  endtask

  task automatic test_timing();
    run_steps(3, 8'd2, 3'($urandom), 5);
  endtask

  task automatic test_counting();
    @(negedge clk); clr_counts = 1'b1;
    @(negedge clk); clr_counts = 1'b0;
    exp_steps = 0;
    for (int i = 0; i < 3; i++) exp_cnt[i] = 0;
    n_chk++;
    if ({spike_counts, step_count} !== '0) $display("FAIL idle_clear: got cnt=%h st=%h want 0", spike_counts, step_count);
    else n_pass++;
    run_steps(300, 8'd0, 3'b011, -1);
  endtask

  task automatic test_random_runs();
    for (int r = 0; r < 4; r++)
      run_steps($urandom_range(1, 20), 8'($urandom_range(0, 5)), 3'($urandom), -1);
  endtask

  task automatic test_clear_collision();
    int cyc = 0;
    step_period = 8'($urandom_range(0, 3));
    bus.layer_spike_out = 3'b111;
    @(negedge clk); run = 1'b1;
    while (!bus.layer_enable && cyc < 20) begin @(negedge clk); cyc++; end
    @(negedge clk);                      // CAPTURE cycle
    clr_counts = 1'b1;
    @(negedge clk);
    clr_counts = 1'b0;
    exp_steps = 0;
    for (int i = 0; i < 3; i++) exp_cnt[i] = 0;
    n_chk++;
    if ({spike_counts, step_count} !== '0)
      $display("FAIL clear_vs_capture: got cnt=%h st=%h want 0", spike_counts, step_count);
    else n_pass++;
    cyc = 0;
    while (!bus.layer_enable && cyc < 20) begin @(negedge clk); cyc++; end
    run = 1'b0;                          // drop run during STEP
    repeat (3) @(negedge clk);
    exp_steps = 1;
    for (int i = 0; i < 3; i++) exp_cnt[i] = 1;
    n_chk++;
    if (busy !== 1'b0) $display("FAIL drop_in_step_busy: got %b want 0", busy);
    else n_pass++;
    n_chk++;
    if ({spike_counts, step_count} !== {cnt_vec(), STEP_W'(exp_steps)})
      $display("FAIL drop_in_step_counts: got cnt=%h st=%0d want cnt=%h st=%0d",
               spike_counts, step_count, cnt_vec(), exp_steps);
    else n_pass++;
  endtask

  task automatic test_reset_midrun();
    int cyc = 0, en_seen = 0;
    step_period = 8'd1;
    @(negedge clk); run = 1'b1;
    while (!bus.layer_enable && cyc < 20) begin @(negedge clk); cyc++; end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    n_chk++;
    if ({bus.layer_weights, bus.layer_params, bus.layer_enable, bus.layer_input_spikes,
         cfg_loaded, busy, spike_counts, step_count} !== '0)
      $display("FAIL reset_midrun: got en=%b ins=%b ld=%b busy=%b cnt=%h st=%h want all 0",
               bus.layer_enable, bus.layer_input_spikes, cfg_loaded, busy, spike_counts, step_count);
    else n_pass++;
    repeat (10) begin
      @(negedge clk);
      if (bus.layer_enable) en_seen++;
    end
    n_chk++;
    if (en_seen !== 0) $display("FAIL after_reset_enable: got %0d want 0", en_seen);
    else n_pass++;
    run = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.cfg_start = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.cfg_byte = '0;
    bus.layer_spike_out = '0;
    model_reset();
    test_reset();
    test_reset_mid_load();
    test_load();
    test_restart();
    test_timing();
    test_counting();
    test_random_runs();
    test_clear_collision();
    test_reload_keeps();
    test_reset_midrun();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
